dec8b10b_sync_ctrl: RTL and testbench
=====================================

Name: dec8b10b_sync_ctrl

Overview:
- Link synchronisation controller placed directly behind the 8B/10B decoder.
- Monitors the decoder's per-word status (code_err, disp_err, k_out) and runs a comma-based acquire/lose-sync state machine.
- Requests deserializer bit-slips while unaligned, gates decoded data to downstream logic only while in sync, and keeps saturating error and sync-loss statistics.

Parameters:
COMMA_K, 8'hBC, decoded byte that, with k=1, counts as a comma (K28.5)
ACQ_COMMAS, 3, error-free commas required in ACQUIRE to declare sync (1..15)
LOSS_ERRS, 4, error level in SYNC that forces loss of sync (1..15)
GOOD_RUN, 4, consecutive good words in SYNC that decrement the error level (1..255)
SLIP_WAIT, 20, valid words without a comma in LOS before a slip request (2..255)
CNT_W, 16, width of err_count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
dec_valid  in  1  decoder output word valid this cycle
dec_data  in  8  decoded byte
dec_k  in  1  control-character flag
dec_code_err  in  1  invalid 10-bit code
dec_disp_err  in  1  running-disparity error
force_resync  in  1  synchronous request to drop to LOS
stats_clear  in  1  clears err_count and loss_count
slip  out  1  one-cycle bit-slip request to the deserializer
sync_ok  out  1  high while in SYNC
rx_valid  out  1  downstream data valid
rx_data  out  8  registered dec_data
rx_k  out  1  registered dec_k
err_count  out  CNT_W  saturating count of errored words
loss_count  out  8  saturating count of SYNC->LOS transitions

Behaviour:
- Definitions: bad = dec_valid & (dec_code_err | dec_disp_err). comma = dec_valid & ~bad & dec_k & (dec_data == COMMA_K). good = dec_valid & ~bad.
- Reset (async): state = LOS, all counters = 0, all outputs = 0.
- Cycles with dec_valid = 0 change nothing, except force_resync and stats_clear.
- force_resync has top priority:
  - next state LOS; comma, good and slip counters cleared; error level = 0.
  - If the current state is SYNC, loss_count increments.
- LOS:
  - comma -> ACQUIRE with comma_cnt = 1.
  - Otherwise each dec_valid word increments slip_cnt.
  - When slip_cnt reaches SLIP_WAIT: slip = 1 for exactly one cycle (registered, asserted the cycle after the triggering word) and slip_cnt = 0.
  - A comma also clears slip_cnt.
- ACQUIRE:
  - bad -> LOS with slip_cnt = 0.
  - comma -> comma_cnt + 1; when the incremented value equals ACQ_COMMAS -> SYNC with error level = 0 and good_cnt = 0.
  - Any other good word -> stay.
  - ACQ_COMMAS = 1 means the first comma in LOS goes straight to SYNC.
- SYNC, with error level e:
  - bad -> e + 1, good_cnt = 0. If e + 1 == LOSS_ERRS -> LOS and loss_count + 1 (saturates at 255).
  - good with e > 0 -> good_cnt + 1. When it reaches GOOD_RUN: e - 1 and good_cnt = 0.
  - good with e = 0 -> good_cnt stays 0.
- Outputs:
  - sync_ok is registered and equals (state == SYNC); it rises the cycle after the transition into SYNC.
  - rx_data and rx_k register dec_data and dec_k on every dec_valid word.
  - rx_valid = registered (dec_valid & ~bad & state == SYNC), evaluated on the state before the update. The word that completes acquisition is therefore not forwarded; the next word is.
  - Fixed latency of 1 clock from dec_* to rx_*.
- err_count:
  - Increments on every bad word, in any state; saturates at all-ones.
  - stats_clear clears err_count and loss_count. When clear and increment coincide, the clear wins and the coincident event is not counted.
- Mid-operation reset returns immediately to LOS with outputs low. No pending slip pulse survives reset.

Test Plan:
1. Reset, then 3 valid words 0xBC/k=1 with no errors, then data 0x55 -> sync_ok rises 1 cycle after the 3rd comma. rx_valid=1 with rx_data=0x55 one cycle after the 0x55 input. No rx_valid for the commas.
2. In LOS, 20 valid non-comma words (0x00, k=0) -> slip pulses exactly once, one cycle after word 20. 40 words produce 2 pulses. A comma at word 10 suppresses the pulse.
3. In ACQUIRE after 2 commas, one word with dec_code_err=1 -> back to LOS. err_count = 1. Three further commas are required before sync_ok = 1.
4. In SYNC, 3 bad words, then 4 good words, then 2 bad words -> error level goes 3→2→4. Sync is lost on the 2nd bad word: sync_ok = 0 next cycle, loss_count = 1, err_count = 5.
5. Drive err_count to 16'hFFFF, then 1 more bad word -> stays 16'hFFFF. stats_clear together with a bad word -> err_count = 0.
6. In SYNC, assert force_resync -> LOS and loss_count + 1. In a separate run, assert reset mid-slip-countdown -> slip = 0 and sync_ok = 0 immediately, all counters 0.

Source files
------------

// File: rtl/dec8b10b_sync_ctrl.sv
// Comma-based link sync controller behind the 8B/10B decoder.
// Gates decoded data while in sync, requests bit-slips and keeps error stats.
module dec8b10b_sync_ctrl #(
  parameter logic [7:0]  COMMA_K    = 8'hBC,
  parameter int unsigned ACQ_COMMAS = 3,
  parameter int unsigned LOSS_ERRS  = 4,
  parameter int unsigned GOOD_RUN   = 4,
  parameter int unsigned SLIP_WAIT  = 20,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [7:0]       dec_data,
  input  logic             dec_k,
  input  logic             dec_code_err,
  input  logic             dec_disp_err,
  input  logic             force_resync,
  input  logic             stats_clear,
  output logic             slip,
  output logic             sync_ok,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_k,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       loss_count
);

  typedef enum logic [1:0] {
    LOS,
    ACQUIRE,
    SYNC
  } state_t;

  localparam logic [3:0] ACQ_N  = 4'(ACQ_COMMAS);
  localparam logic [3:0] LOSS_N = 4'(LOSS_ERRS);
  localparam logic [7:0] RUN_N  = 8'(GOOD_RUN);
  localparam logic [7:0] SLIP_N = 8'(SLIP_WAIT);

  state_t     state_q, state_d;
  logic [7:0] slip_cnt_q, slip_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [3:0] elvl_q, elvl_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic       slip_d;
  logic       loss_evt;

  logic bad, good, comma;

  assign bad   = dec_valid & (dec_code_err | dec_disp_err);
  assign good  = dec_valid & ~bad;
  assign comma = good & dec_k & (dec_data == COMMA_K);

  always_comb begin
    state_d     = state_q;
    slip_cnt_d  = slip_cnt_q;
    comma_cnt_d = comma_cnt_q;
    elvl_d      = elvl_q;
    good_cnt_d  = good_cnt_q;
    slip_d      = 1'b0;
    loss_evt    = 1'b0;
    if (force_resync) begin
      state_d     = LOS;
      slip_cnt_d  = '0;
      comma_cnt_d = '0;
      elvl_d      = '0;
      good_cnt_d  = '0;
      loss_evt    = (state_q == SYNC);
    end else if (dec_valid) begin
      unique case (state_q)
        LOS: begin
          if (comma) begin
            slip_cnt_d = '0;
            if (ACQ_N == 4'd1) begin
              state_d     = SYNC;
              comma_cnt_d = '0;
              elvl_d      = '0;
              good_cnt_d  = '0;
            end else begin
              state_d     = ACQUIRE;
              comma_cnt_d = 4'd1;
            end
          end else if (slip_cnt_q + 8'd1 == SLIP_N) begin
            slip_d     = 1'b1;
            slip_cnt_d = '0;
          end else begin
            slip_cnt_d = slip_cnt_q + 8'd1;
          end
        end
        ACQUIRE: begin
          if (bad) begin
            state_d     = LOS;
            slip_cnt_d  = '0;
            comma_cnt_d = '0;
          end else if (comma) begin
            if (comma_cnt_q + 4'd1 == ACQ_N) begin
              state_d     = SYNC;
              comma_cnt_d = '0;
              elvl_d      = '0;
              good_cnt_d  = '0;
            end else begin
              comma_cnt_d = comma_cnt_q + 4'd1;
            end
          end
        end
        SYNC: begin
          if (bad) begin
            good_cnt_d = '0;
            if (elvl_q + 4'd1 == LOSS_N) begin
              state_d    = LOS;
              elvl_d     = '0;
              slip_cnt_d = '0;
              loss_evt   = 1'b1;
            end else begin
              elvl_d = elvl_q + 4'd1;
            end
          end else if (elvl_q != 4'd0) begin
            // a full run of clean words pays back one error
            if (good_cnt_q + 8'd1 == RUN_N) begin
              elvl_d     = elvl_q - 4'd1;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end
        end
        default: state_d = LOS;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= LOS;
      slip_cnt_q  <= '0;
      comma_cnt_q <= '0;
      elvl_q      <= '0;
      good_cnt_q  <= '0;
      slip        <= 1'b0;
      sync_ok     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_k        <= 1'b0;
      err_count   <= '0;
      loss_count  <= '0;
    end else begin
      state_q     <= state_d;
      slip_cnt_q  <= slip_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      elvl_q      <= elvl_d;
      good_cnt_q  <= good_cnt_d;
      slip        <= slip_d;
      sync_ok     <= (state_d == SYNC);
      rx_valid    <= good & (state_q == SYNC);
      if (dec_valid) begin
        rx_data <= dec_data;
        rx_k    <= dec_k;
      end
      // a coincident clear swallows the event
      if (stats_clear) begin
        err_count <= '0;
      end else if (bad && err_count != '1) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (stats_clear) begin
        loss_count <= '0;
      end else if (loss_evt && loss_count != 8'hFF) begin
        loss_count <= loss_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dec8b10b_sync_ctrl.sv
// Bench for dec8b10b_sync_ctrl: directed plan scenarios plus
// randomized traffic against a rule-level reference model.
module tb_dec8b10b_sync_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [7:0]  dec_data;
  logic        dec_k;
  logic        dec_code_err;
  logic        dec_disp_err;
  logic        force_resync;
  logic        stats_clear;
  logic        slip;
  logic        sync_ok;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_k;
  logic [15:0] err_count;
  logic [7:0]  loss_count;

  int n_chk = 0;
  int n_fail = 0;

  dec8b10b_sync_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_data     (dec_data),
    .dec_k        (dec_k),
    .dec_code_err (dec_code_err),
    .dec_disp_err (dec_disp_err),
    .force_resync (force_resync),
    .stats_clear  (stats_clear),
    .slip         (slip),
    .sync_ok      (sync_ok),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_k         (rx_k),
    .err_count    (err_count),
    .loss_count   (loss_count)
  );

  always #5 clock = ~clock;

  // Reference model: link phase and counters as plain integers.
  localparam int P_LOS = 0, P_ACQ = 1, P_SYNC = 2;
  int m_phase, m_idle_words, m_commas, m_level, m_run;
  int m_err, m_loss;
  logic m_slip, m_sync, m_rxv, m_rxk;
  logic [7:0] m_rxd;

  function automatic void model_reset();
    m_phase = P_LOS; m_idle_words = 0; m_commas = 0;
    m_level = 0; m_run = 0; m_err = 0; m_loss = 0;
    m_slip = 0; m_sync = 0; m_rxv = 0; m_rxk = 0; m_rxd = 0;
  endfunction

  function automatic void enter_los();
    m_phase = P_LOS; m_idle_words = 0; m_commas = 0;
    m_level = 0; m_run = 0;
  endfunction

  function automatic void model_step(logic v, logic [7:0] d, logic k,
                                     logic ce, logic de, logic fr,
                                     logic sc);
    bit is_bad, is_good, is_comma, lost;
    is_bad   = v && (ce || de);
    is_good  = v && !is_bad;
    is_comma = is_good && k && (d == 8'hBC);
    lost     = 0;
    m_slip   = 0;
    m_rxv    = is_good && (m_phase == P_SYNC);
    if (v) begin m_rxd = d; m_rxk = k; end
    if (sc) m_err = 0;
    else if (is_bad) m_err = (m_err == 65535) ? 65535 : m_err + 1;
    if (fr) begin
      lost = (m_phase == P_SYNC);
      enter_los();
    end else if (v) begin
      if (m_phase == P_LOS) begin
        if (is_comma) begin
          m_idle_words = 0; m_commas = 1; m_phase = P_ACQ;
        end else begin
          m_idle_words++;
          if (m_idle_words == 20) begin m_slip = 1; m_idle_words = 0; end
        end
      end else if (m_phase == P_ACQ) begin
        if (is_bad) enter_los();
        else if (is_comma) begin
          m_commas++;
          if (m_commas == 3) begin
            m_phase = P_SYNC; m_level = 0; m_run = 0;
          end
        end
      end else begin
        if (is_bad) begin
          m_level++; m_run = 0;
          if (m_level == 4) begin lost = 1; enter_los(); end
        end else if (m_level > 0) begin
          m_run++;
          if (m_run == 4) begin m_level--; m_run = 0; end
        end
      end
    end
    if (sc) m_loss = 0;
    else if (lost) m_loss = (m_loss == 255) ? 255 : m_loss + 1;
    m_sync = (m_phase == P_SYNC);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic k,
                       input logic ce, input logic de, input logic fr,
                       input logic sc);
    dec_valid = v; dec_data = d; dec_k = k;
    dec_code_err = ce; dec_disp_err = de;
    force_resync = fr; stats_clear = sc;
    model_step(v, d, k, ce, de, fr, sc);
    @(posedge clock);
    #1;
  endtask

  task automatic comma_w();
    drive(1, 8'hBC, 1, 0, 0, 0, 0);
  endtask

  task automatic data_w(input logic [7:0] d);
    drive(1, d, 0, 0, 0, 0, 0);
  endtask

  task automatic bad_w();
    drive(1, 8'h00, 0, 1, 0, 0, 0);
  endtask

  task automatic idle_w();
    drive(0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    dec_valid = 0; dec_data = 0; dec_k = 0;
    dec_code_err = 0; dec_disp_err = 0;
    force_resync = 0; stats_clear = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({slip, sync_ok, rx_valid, rx_data, rx_k, err_count, loss_count}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_state: slip=%b sync=%b rxv=%b rxd=%h rxk=%b err=%0d loss=%0d, required all zero",
               slip, sync_ok, rx_valid, rx_data, rx_k, err_count, loss_count);
    end
  endtask

  task automatic test_acquire();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      comma_w();
      n_chk++;
      if (sync_ok !== (i == 2) || rx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL acq_comma%0d: sync=%b rxv=%b, required sync=%b rxv=0",
                 i, sync_ok, rx_valid, i == 2);
      end
    end
    data_w(8'h55);
    n_chk++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h55 || rx_k !== 1'b0) begin
      n_fail++;
      $display("FAIL acq_first_data: rxv=%b rxd=%h rxk=%b, required 1 55 0",
               rx_valid, rx_data, rx_k);
    end
  endtask

  task automatic test_slip();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      data_w(8'h00);
      if (slip === 1'b1) pulses++;
      n_chk++;
      if (slip !== (i == 19 || i == 39)) begin
        n_fail++;
        $display("FAIL slip_word%0d: slip=%b, required %b",
                 i + 1, slip, i == 19 || i == 39);
      end
    end
    n_chk++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL slip_count40: pulses=%0d, required 2", pulses);
    end
    do_reset();
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 9) comma_w(); else data_w(8'h00);
      if (slip === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL slip_comma_suppress: pulses=%0d, required 0", pulses);
    end
  endtask

  task automatic test_acq_abort();
    do_reset();
    comma_w();
    comma_w();
    bad_w();
    n_chk++;
    if (sync_ok !== 1'b0 || err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL acq_abort: sync=%b err=%0d, required 0 1",
               sync_ok, err_count);
    end
    comma_w();
    comma_w();
    n_chk++;
    if (sync_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL acq_abort_2commas: sync=%b, required 0", sync_ok);
    end
    comma_w();
    n_chk++;
    if (sync_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL acq_abort_3commas: sync=%b, required 1", sync_ok);
    end
  endtask

  task automatic test_err_level();
    do_reset();
    repeat (3) comma_w();
    repeat (3) bad_w();
    repeat (4) data_w(8'hA5);
    bad_w();
    n_chk++;
    if (sync_ok !== 1'b1 || loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL level_hold: sync=%b loss=%0d, required 1 0",
               sync_ok, loss_count);
    end
    bad_w();
    n_chk++;
    if (sync_ok !== 1'b0 || loss_count !== 8'd1 || err_count !== 16'd5) begin
      n_fail++;
      $display("FAIL level_loss: sync=%b loss=%0d err=%0d, required 0 1 5",
               sync_ok, loss_count, err_count);
    end
  endtask

  task automatic test_err_sat();
    do_reset();
    repeat (65535) bad_w();
    n_chk++;
    if (err_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL err_reach_max: err=%h, required ffff", err_count);
    end
    bad_w();
    n_chk++;
    if (err_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL err_saturate: err=%h, required ffff", err_count);
    end
    drive(1, 8'h00, 0, 0, 1, 0, 1);
    n_chk++;
    if (err_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL err_clear_wins: err=%h, required 0000", err_count);
    end
  endtask

  task automatic test_force_resync();
    do_reset();
    repeat (3) comma_w();
    drive(0, 8'h00, 0, 0, 0, 1, 0);
    n_chk++;
    if (sync_ok !== 1'b0 || loss_count !== 8'd1) begin
      n_fail++;
      $display("FAIL force_resync: sync=%b loss=%0d, required 0 1",
               sync_ok, loss_count);
    end
    repeat (2) comma_w();
    n_chk++;
    if (sync_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL force_reacq: sync=%b, required 0", sync_ok);
    end
    drive(0, 8'h00, 0, 0, 0, 1, 0);
    n_chk++;
    if (loss_count !== 8'd1) begin
      n_fail++;
      $display("FAIL force_in_acq: loss=%0d, required 1", loss_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) bad_w();
    repeat (17) data_w(8'h11);
    n_chk++;
    if (slip !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_slip: slip=%b, required 1", slip);
    end
    reset = 1;
    #1;
    n_chk++;
    if (slip !== 1'b0 || sync_ok !== 1'b0 || err_count !== 16'd0 ||
        loss_count !== 8'd0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: slip=%b sync=%b err=%0d loss=%0d rxv=%b, required all 0",
               slip, sync_ok, err_count, loss_count, rx_valid);
    end
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();
    repeat (3) comma_w();
    reset = 1;
    #1;
    n_chk++;
    if (sync_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_sync: sync=%b, required 0", sync_ok);
    end
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_random();
    logic v, k, ce, de, fr, sc;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      v  = ($urandom_range(7) != 0);
      k  = ($urandom_range(9) < 5);
      d  = k && ($urandom_range(9) < 8) ? 8'hBC : 8'($urandom);
      ce = ($urandom_range(24) == 0);
      de = ($urandom_range(24) == 0);
      fr = ($urandom_range(299) == 0);
      sc = ($urandom_range(199) == 0);
      drive(v, d, k, ce, de, fr, sc);
      n_chk++;
      if (slip !== m_slip || sync_ok !== m_sync || rx_valid !== m_rxv ||
          rx_data !== m_rxd || rx_k !== m_rxk ||
          err_count !== 16'(m_err) || loss_count !== 8'(m_loss)) begin
        n_fail++;
        $display("FAIL random_cyc%0d: slip=%b sync=%b rxv=%b rxd=%h rxk=%b err=%0d loss=%0d, required %b %b %b %h %b %0d %0d",
                 i, slip, sync_ok, rx_valid, rx_data, rx_k, err_count,
                 loss_count, m_slip, m_sync, m_rxv, m_rxd, m_rxk, m_err,
                 m_loss);
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_slip();
    test_acq_abort();
    test_err_level();
    test_err_sat();
    test_force_resync();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
